// File: rtl/div32_seq.sv
// Sequential 32-bit restoring divider for RV32M DIV/DIVU/REM/REMU (33-cycle latency).
// Define DIV_EARLY_OUT_EN to finish divide-by-zero / overflow cases in one cycle.
module div32_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] res
);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t      r_state, w_next;
  logic [1:0]  r_op;
  logic [31:0] r_a, r_div, r_quo, r_rem, r_res;
  logic [4:0]  r_cnt;
  logic        r_qneg, r_rneg, r_div0, r_ovf, r_done;

  logic        w_sgn, w_div0, w_ovf;
  logic [31:0] w_amag, w_bmag, w_q, w_r, w_fin;
  logic [32:0] w_sh, w_diff;

  assign w_sgn  = ~op[0];
  assign w_div0 = (b == 32'h0);
  assign w_ovf  = w_sgn && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  assign w_amag = (w_sgn && a[31]) ? -a : a;
  assign w_bmag = (w_sgn && b[31]) ? -b : b;

  // Restored remainder is always below the divisor, so 32 bits are stored;
  // the 33-bit partial remainder exists as the shifted trial operand.
  assign w_sh   = {r_rem, r_quo[31]};
  assign w_diff = w_sh - {1'b0, r_div};

  always_comb begin
    w_q = (~r_op[0] && r_qneg) ? -r_quo : r_quo;
    w_r = (~r_op[0] && r_rneg) ? -r_rem : r_rem;
    if (r_div0) begin
      w_q = 32'hFFFF_FFFF;
      w_r = r_a;
    end else if (r_ovf) begin
      w_q = 32'h8000_0000;
      w_r = 32'h0;
    end
    w_fin = r_op[1] ? w_r : w_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (start) begin
`ifdef DIV_EARLY_OUT_EN
        w_next = (w_div0 || w_ovf) ? FIN : CALC;
`else
        w_next = CALC;
`endif
      end
      CALC: if (r_cnt == 5'd31) w_next = FIN;
      FIN:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op   <= 2'b0;
      r_a    <= 32'h0;
      r_div  <= 32'h0;
      r_quo  <= 32'h0;
      r_rem  <= 32'h0;
      r_res  <= 32'h0;
      r_cnt  <= 5'd0;
      r_qneg <= 1'b0;
      r_rneg <= 1'b0;
      r_div0 <= 1'b0;
      r_ovf  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_op   <= op;
          r_a    <= a;
          r_quo  <= w_amag;
          r_div  <= w_bmag;
          r_qneg <= a[31] ^ b[31];
          r_rneg <= a[31];
          r_div0 <= w_div0;
          r_ovf  <= w_ovf;
          r_rem  <= 32'h0;
          r_cnt  <= 5'd0;
        end
        CALC: begin
          if (!w_diff[32]) begin
            r_rem <= w_diff[31:0];
            r_quo <= {r_quo[30:0], 1'b1};
          end else begin
            r_rem <= w_sh[31:0];
            r_quo <= {r_quo[30:0], 1'b0};
          end
          r_cnt <= r_cnt + 5'd1;
        end
        FIN: begin
          r_res  <= w_fin;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state != IDLE);
  assign done = r_done;
  assign res  = r_res;

endmodule

// File: tb/tb_div32_seq.sv
// Directed self-checking bench for div32_seq: results, latency, busy window,
// ignored start, back-to-back start and mid-operation reset.
module tb_div32_seq;

  logic        clk, rst_n, start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] res;

  int checks = 0;
  int fails  = 0;

`ifdef DIV_EARLY_OUT_EN
  localparam int SPEC_LAT = 1;
`else
  localparam int SPEC_LAT = 33;
`endif

  localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;

  div32_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .res(res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Waits for done after an accepted start; n counts edges since the accept edge.
  task automatic wait_done(input int n0, output int n, output logic busy_ok);
    n = n0;
    busy_ok = 1'b1;
    while (n < 100) begin
      @(posedge clk); #1;
      n++;
      if (done) break;
      if (!busy) busy_ok = 1'b0;
    end
  endtask

  // Called #1 after a posedge; start is sampled at the next edge.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp, input int lat);
    int n;
    logic bok;
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = 32'hDEAD_BEEF; b = 32'h1234_5678; op = ~o;
    chk({tag, "_busy_k"}, {31'b0, busy}, 32'd1);
    wait_done(0, n, bok);
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_res"}, res, exp);
    chk({tag, "_busy_win"}, {31'b0, bok}, 32'd1);
    chk({tag, "_busy_done"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int n;
    logic bok, extra;
    rst_n = 1'b0; start = 1'b0; op = 2'b0; a = 32'h0; b = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_res", res, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("divu_100_7", DIVU, 32'd100, 32'd7, 32'd14, 33);
    run_op("remu_100_7", REMU, 32'd100, 32'd7, 32'd2, 33);
    run_op("div_m7_2",   DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_op("rem_m7_2",   REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_op("rem_7_m2",   REM,  32'd7, 32'hFFFF_FFFE, 32'd1, 33);
    run_op("divu_big",   DIVU, 32'h8000_0000, 32'd3, 32'h2AAA_AAAA, 33);
    run_op("remu_big",   REMU, 32'h8000_0000, 32'd3, 32'd2, 33);
    run_op("divu_max_1", DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33);

    run_op("divu_by0",   DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, SPEC_LAT);
    run_op("remu_by0",   REMU, 32'd5, 32'd0, 32'd5, SPEC_LAT);
    run_op("div_by0",    DIV,  32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, SPEC_LAT);
    run_op("rem_by0",    REM,  32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, SPEC_LAT);
    run_op("div_ovf",    DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPEC_LAT);
    run_op("rem_ovf",    REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, SPEC_LAT);

    // Second start at k+10 must be ignored.
    op = DIVU; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    op = DIVU; a = 32'd9; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(10, n, bok);
    chk("ign_lat", n, 33);
    chk("ign_res", res, 32'd14);
    chk("ign_busy_win", {31'b0, bok}, 32'd1);
    extra = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (done || busy) extra = 1'b1; end
    chk("ign_no_second_done", {31'b0, extra}, 32'd0);

    // Back-to-back: second start issued in the done cycle.
    run_op("b2b_first",  DIVU, 32'd100, 32'd7, 32'd14, 33);
    run_op("b2b_second", DIVU, 32'd9, 32'd3, 32'd3, 33);

    // Reset at k+15 aborts the operation.
    op = DIVU; a = 32'd1000; b = 32'd10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) begin @(posedge clk); #1; end
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_done", {31'b0, done}, 32'd0);
    chk("arst_res", res, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    extra = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (done || busy) extra = 1'b1; end
    chk("arst_no_done", {31'b0, extra}, 32'd0);
    run_op("post_rst", DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 33);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/div32_seq.md
# div32_seq

Iterative 32-bit radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions; the division counterpart of the combinational `mul32` multiplier in the ALU. It accepts one operation per start/done handshake, computes the result over 33 clock cycles, and applies RISC-V sign rules and special-case results. The execute stage stalls on `busy` and captures `res` on `done`.

## Interface
- No parameters; width fixed at 32.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous reset, active low.
- `start`  in  1  request a new operation; sampled only when idle.
- `op`  in  2  operation code, equal to funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `a`  in  32  dividend (rs1).
- `b`  in  32  divisor (rs2).
- `busy`  out  1  high while an operation is in progress.
- `done`  out  1  single-cycle pulse; `res` is valid in this cycle.
- `res`  out  32  quotient for DIV/DIVU, remainder for REM/REMU.

## Operation
- States:
  - IDLE → CALC when `start`=1.
  - CALC (32 iterations) → FIN.
  - FIN → IDLE.
- IDLE accepting `start`:
  - Latch `op`.
  - Latch magnitudes |a| and |b| for signed ops, raw values for unsigned ops.
  - Latch the quotient sign (a[31]^b[31]) and the remainder sign (a[31]).
  - Latch special-case flags: div0 (b==0) and ovf (DIV/REM with a=0x80000000, b=0xFFFFFFFF).
  - Clear the 33-bit partial remainder and the 5-bit iteration counter.
- CALC iteration:
  - Shift {rem, quo} left by 1.
  - Trial subtract the divisor from the 33-bit partial remainder.
  - If the result is non-negative, keep it and set the quotient LSB to 1; otherwise restore and set the LSB to 0.
  - The counter counts 0..31; leave CALC after iteration 31.
- FIN:
  - Negate the quotient if its sign flag is set; negate the remainder if its sign flag is set.
  - Select the quotient or remainder by `op`[1].
  - Apply special cases, which take priority over computed values:
    - div0: quotient 0xFFFFFFFF; remainder = original `a`.
    - ovf: quotient 0x80000000; remainder 0.
  - Register `res`, pulse `done`, return to IDLE.
- `res` holds its value until the next `done`.
- `start` while `busy`=1 is ignored; inputs may change freely after acceptance.
- Reset during any state forces IDLE immediately and discards the operation; no `done` is produced for it.

## Timing
- Reset values: `busy`=0, `done`=0, `res`=0x00000000, state IDLE.
- Handshake cycle numbering, with `start` sampled at edge k:
  - `busy` is high from edge k to edge k+33.
  - CALC iterations occur at edges k+1..k+32.
  - `res` and `done` are registered at edge k+33.
  - Latency from `start` edge to `done`: 33 cycles.
- `done` is high for exactly one cycle and `busy` is 0 in that cycle.
- A `start` asserted in the `done` cycle is accepted, so back-to-back throughput is one result per 33 cycles.
- Outputs are fully registered; there is no combinational path from inputs to outputs.

## Configuration
- `DIV_EARLY_OUT_EN` defined:
  - When div0 or ovf is detected at acceptance, the block skips CALC and goes IDLE→FIN.
  - `done` and the special result appear at edge k+1, a latency of 1 cycle.
- Not defined:
  - Special cases run the full 32 iterations.
  - The forced special-case values still replace the computed result in FIN, with latency 33.

## Test plan
- DIVU a=100, b=7 → `res`=14; REMU with the same operands → `res`=2. `done` is asserted 33 cycles after `start`; `busy` covers edges k..k+33.
- DIV a=0xFFFFFFF9 (-7), b=2 → 0xFFFFFFFD (-3); REM with the same operands → 0xFFFFFFFF (-1); REM a=7, b=0xFFFFFFFE → 1.
- Divide by zero:
  - DIVU a=5, b=0 → 0xFFFFFFFF; REMU → 5; DIV a=0xFFFFFFF9, b=0 → 0xFFFFFFFF.
  - Latency is 1 cycle with `DIV_EARLY_OUT_EN`, 33 without.
- Overflow: DIV a=0x80000000, b=0xFFFFFFFF → 0x80000000; REM → 0. Latency as for divide by zero.
- Second `start` (DIVU 9/3) pulsed at cycle k+10 of a running DIVU 100/7 → ignored; the single `done` carries 14. `start` in the `done` cycle → accepted, and the next `done` arrives 33 cycles later.
- `rst_n` pulled low at cycle k+15 → `busy`, `done` and `res` are 0 immediately, and no `done` follows. A new op after release completes normally.
